bcd_to_bin: RTL and testbench



---
 rtl/bcd_to_bin.sv | 140 ++++++++++++++
 tb/tb_bcd_to_bin.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/bcd_to_bin.sv
// bcd_to_bin: sequential BCD-to-binary converter (reverse double dabble).
//   A start pulse seen while idle loads a packed DIGITS-digit BCD value.
//   BW shift cycles follow, then a one-cycle done pulse, BW+2 cycles per
//   conversion in total.
// Ports:
//   clk    - clock, rising edge
//   rst_n  - synchronous active-low reset
//   start  - conversion request, sampled only while idle
//   bcd    - packed BCD input, digit k in bits [4k+3:4k]
//   busy   - high from the cycle after start through the done cycle
//   done   - one-cycle pulse, bin/err freshly updated
//   bin    - binary result, held until the next done
//   err    - some input digit was > 9 (bin forced to 0), held with bin
module bcd_to_bin #(
   parameter int DIGITS = 3,
   parameter int BW     = 10
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [4*DIGITS-1:0]   bcd,
   output logic                  busy,
   output logic                  done,
   output logic [BW-1:0]         bin,
   output logic                  err
);

   localparam int BCDW = 4 * DIGITS;
   localparam int SRW  = BCDW + BW;
   localparam int CW   = $clog2(BW + 1);

   // The binary field must hold the largest decimal value.
   generate
      if ((2 ** BW) <= (10 ** DIGITS) - 1) begin : g_bw_too_small
         $error("bcd_to_bin: BW too small for DIGITS");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state_q, state_d;
   logic [SRW-1:0]   sr_q, sr_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             err_nxt_q, err_nxt_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [BW-1:0]    bin_q, bin_d;
   logic             err_q, err_d;
   logic [SRW-1:0]   sr_fix;
   logic             bad_digit;

   // Any digit above 9 makes the input invalid.
   always_comb begin
      bad_digit = 1'b0;
      for (int k = 0; k < DIGITS; k++) begin
         if (bcd[4*k +: 4] > 4'd9) bad_digit = 1'b1;
      end
   end

   // One reverse-dabble step: shift right, then every BCD digit that is
   // now >= 8 loses 3. Digits are corrected independently, no carries.
   always_comb begin
      sr_fix = sr_q >> 1;
      for (int k = 0; k < DIGITS; k++) begin
         if (sr_fix[BW + 4*k + 3]) begin
            sr_fix[BW + 4*k +: 4] = sr_fix[BW + 4*k +: 4] - 4'd3;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      sr_d      = sr_q;
      cnt_d     = cnt_q;
      err_nxt_d = err_nxt_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      bin_d     = bin_q;
      err_d     = err_q;
      case (state_q)
         IDLE: begin
            busy_d = 1'b0;
            if (start) begin
               sr_d      = {bcd, {BW{1'b0}}};
               cnt_d     = '0;
               err_nxt_d = bad_digit;
               busy_d    = 1'b1;
               state_d   = SHIFT;
            end
         end
         SHIFT: begin
            sr_d  = sr_fix;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(BW - 1)) begin
               // Outputs load on the edge into DONE from the final shift.
               state_d = DONE;
               done_d  = 1'b1;
               bin_d   = err_nxt_q ? '0 : sr_fix[BW-1:0];
               err_d   = err_nxt_q;
            end
         end
         DONE: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         sr_q      <= '0;
         cnt_q     <= '0;
         err_nxt_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         bin_q     <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         sr_q      <= sr_d;
         cnt_q     <= cnt_d;
         err_nxt_q <= err_nxt_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         bin_q     <= bin_d;
         err_q     <= err_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign bin  = bin_q;
   assign err  = err_q;

endmodule

// File: tb/tb_bcd_to_bin.sv
// tb_bcd_to_bin: directed bench for bcd_to_bin. Covers a 3-digit instance
// (BW=10) and a 2-digit instance (BW=7).
module tb_bcd_to_bin;

   logic        clk;
   logic        rst_n;
   logic        start, start2;
   logic [11:0] bcd;
   logic [7:0]  bcd2;
   logic        busy, done, err, busy2, done2, err2;
   logic [9:0]  bin;
   logic [6:0]  bin2;

   int vecs  = 0;
   int fails = 0;
   int cyc;
   int ndone;

   bcd_to_bin #(.DIGITS(3), .BW(10)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .bcd(bcd),
      .busy(busy), .done(done), .bin(bin), .err(err));

   bcd_to_bin #(.DIGITS(2), .BW(7)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .bcd(bcd2),
      .busy(busy2), .done(done2), .bin(bin2), .err(err2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vecs++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Advance one edge; sample/drive 1 time unit after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Wait (bounded) for done on the 3-digit instance; cyc counts cycles.
   task automatic wait_done();
      while (!done && cyc < 40) begin
         tick();
         cyc++;
      end
   endtask

   task automatic conv(input logic [11:0] v, input int exp_bin, input logic exp_err, input string tag);
      start = 1'b1; bcd = v;
      tick(); cyc = 1;
      start = 1'b0;
      chk({tag, "_busy"}, 32'(busy), 1);
      wait_done();
      chk({tag, "_lat"}, cyc, 11);
      chk({tag, "_bin"}, 32'(bin), exp_bin);
      chk({tag, "_err"}, 32'(err), 32'(exp_err));
      tick();
      chk({tag, "_done_drop"}, 32'(done), 0);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; start2 = 1'b0; bcd = '0; bcd2 = '0;
      #1;
      tick(); tick();
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_bin",  32'(bin),  0);
      chk("rst_err",  32'(err),  0);
      rst_n = 1'b1;
      tick();

      // Basic conversion, busy through all 11 cycles after start.
      start = 1'b1; bcd = 12'h255;
      tick(); cyc = 1; start = 1'b0;
      ndone = 0;
      while (!done && cyc < 40) begin
         if (!busy) ndone++;
         tick(); cyc++;
      end
      chk("b255_busy_gaps", ndone, 0);
      chk("b255_busy_done", 32'(busy), 1);
      chk("b255_lat", cyc, 11);
      chk("b255_bin", 32'(bin), 255);
      chk("b255_err", 32'(err), 0);
      tick(); tick();

      // Back-to-back with start held high.
      start = 1'b1; bcd = 12'h999;
      tick(); cyc = 1;
      wait_done();
      chk("b2b_lat1", cyc, 11);
      chk("b2b_bin1", 32'(bin), 999);
      chk("b2b_err1", 32'(err), 0);
      bcd = 12'h000;
      tick(); cyc++;
      chk("b2b_idle", 32'(busy), 0);
      tick(); cyc++;
      wait_done();
      start = 1'b0;
      chk("b2b_lat2", cyc, 23);
      chk("b2b_bin2", 32'(bin), 0);
      chk("b2b_err2", 32'(err), 0);
      tick(); tick();

      // Invalid digit, then valid.
      conv(12'h0A7, 0, 1'b1, "bad0a7");
      conv(12'h107, 107, 1'b0, "b107");

      // start pulses during SHIFT and DONE are ignored.
      start = 1'b1; bcd = 12'h321;
      tick(); cyc = 1; start = 1'b0;
      tick(); cyc++;
      start = 1'b1; bcd = 12'h555;
      tick(); cyc++;
      start = 1'b0;
      wait_done();
      chk("ign_lat", cyc, 11);
      chk("ign_bin", 32'(bin), 321);
      start = 1'b1;
      tick();
      start = 1'b0;
      ndone = 0;
      for (int i = 0; i < 20; i++) begin
         if (done) ndone++;
         tick();
      end
      chk("ign_no_second", ndone, 0);
      chk("ign_bin_held", 32'(bin), 321);

      // Reset mid-conversion aborts without a done.
      start = 1'b1; bcd = 12'h640;
      tick(); cyc = 1; start = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("abort_busy", 32'(busy), 0);
      chk("abort_bin",  32'(bin),  0);
      chk("abort_err",  32'(err),  0);
      ndone = 0;
      for (int i = 0; i < 15; i++) begin
         if (done) ndone++;
         tick();
      end
      chk("abort_no_done", ndone, 0);
      conv(12'h640, 640, 1'b0, "b640");

      // Exhaustive 3-digit sweep.
      for (int i = 0; i < 1000; i++) begin
         start = 1'b1;
         bcd = {4'(i / 100), 4'((i / 10) % 10), 4'(i % 10)};
         tick(); cyc = 1; start = 1'b0;
         wait_done();
         chk("ex3_lat", cyc, 11);
         chk("ex3_bin", 32'(bin), i);
         chk("ex3_err", 32'(err), 0);
         chk("ex3_sr_bcd", 32'(dut.sr_q[21:10]), 0);
         tick();
      end

      // Exhaustive 2-digit sweep, BW=7 (done 8 cycles after start).
      for (int i = 0; i < 100; i++) begin
         start2 = 1'b1;
         bcd2 = {4'(i / 10), 4'(i % 10)};
         tick(); cyc = 1; start2 = 1'b0;
         while (!done2 && cyc < 40) begin
            tick(); cyc++;
         end
         chk("ex2_lat", cyc, 8);
         chk("ex2_bin", 32'(bin2), i);
         chk("ex2_err", 32'(err2), 0);
         chk("ex2_sr_bcd", 32'(dut2.sr_q[14:7]), 0);
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
      $finish;
   end

endmodule
